// File: rtl/stopwatch_display.sv
// Seven-segment scan back-end for the stopwatch: snapshots packed-BCD time once per frame
// and multiplexes it across 8 common-anode digits with lap hold and leading-zero blanking.
`timescale 1ns/1ps
module stopwatch_display #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic [35:0] time_i,
  input  logic        view_i,
  input  logic        hold_i,
  input  logic        blank_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [35:0]   shadow_q, shadow_d;
  logic          view_q, view_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          frame_end;
  logic [3:0]    nib [8];
  logic [7:0]    mapped;
  logic [7:0]    blank_lz;
  logic          run;
  int unsigned   s1_pos;
  logic          dark;
  logic          dp_lit;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Scan timing and frame-synchronous snapshot
  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    frame_end = tick && (idx_q == 3'd7);
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
    shadow_d  = shadow_q;
    view_d    = view_q;
    if (frame_end && !hold_i) begin
      shadow_d = time_i;
      view_d   = view_i;
    end
  end

  // View 0 shows ms1..m2 on digits 0..6; view 1 drops ms1 and shifts up by one nibble.
  always_comb begin
    for (int d = 0; d < 8; d++) begin
      nib[d]    = 4'h0;
      mapped[d] = 1'b0;
      if (view_q) begin
        nib[d]    = shadow_q[4*(d+1) +: 4];
        mapped[d] = 1'b1;
      end else if (d < 7) begin
        nib[d]    = shadow_q[4*d +: 4];
        mapped[d] = 1'b1;
      end
    end
  end

  // Blank a contiguous run of zeros from the top; the s1 digit and below always stay lit.
  always_comb begin
    blank_lz = '0;
    run      = blank_i;
    s1_pos   = view_q ? 2 : 3;
    for (int d = 7; d >= 0; d--) begin
      if (mapped[d]) begin
        if (run && (d > int'(s1_pos)) && (nib[d] == 4'h0)) begin
          blank_lz[d] = 1'b1;
        end else begin
          run = 1'b0;
        end
      end
    end
  end

  always_comb begin
    dark = !mapped[idx_q] || blank_lz[idx_q];
    if (view_q) begin
      dp_lit = (idx_q == 3'd2) || (idx_q == 3'd4) || (idx_q == 3'd6);
    end else begin
      dp_lit = (idx_q == 3'd3) || (idx_q == 3'd5);
    end
    if (dark) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = decode(nib[idx_q]);
      dp_d  = ~dp_lit;
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= '0;
      view_q   <= 1'b0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      view_q   <= view_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display at SCAN_DIV = 4: scan order, views, frame capture,
// lap hold, leading-zero blanking and asynchronous reset.
`timescale 1ns/1ps
module tb_stopwatch_display;

  logic        clk_i = 1'b0;
  logic        reset;
  logic [35:0] time_i;
  logic        view_i, hold_i, blank_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_display #(.SCAN_DIV(4)) dut (
    .clk_i   (clk_i),
    .reset   (reset),
    .time_i  (time_i),
    .view_i  (view_i),
    .hold_i  (hold_i),
    .blank_i (blank_i),
    .an_o    (an_o),
    .seg_o   (seg_o),
    .dp_o    (dp_o)
  );

  always #5 clk_i = ~clk_i;

  // Anode patterns, slot 7 first
  localparam logic [63:0] AN_V0  = 64'hFF_BF_DF_EF_F7_FB_FD_FE;
  localparam logic [63:0] AN_V1  = 64'h7F_BF_DF_EF_F7_FB_FD_FE;
  localparam logic [63:0] AN_B4  = 64'hFF_FF_FF_FF_F7_FB_FD_FE;
  localparam logic [63:0] AN_B3  = 64'hFF_FF_FF_FF_FF_FB_FD_FE;

  localparam logic [55:0] SEG_F1 = {7'h7F, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [55:0] SEG_F2 = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  localparam logic [55:0] SEG_F3 = {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79};
  localparam logic [55:0] SEG_F4 = {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10};
  localparam logic [55:0] SEG_F6 = {7'h7F, 7'h40, 7'h12, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};
  localparam logic [55:0] SEG_F7 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [55:0] SEG_F8 = {7'h7F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [55:0] SEG_F9 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h79, 7'h40};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " an"},  an_o, 8'hFF);
    check({tag, " seg"}, {1'b0, seg_o}, 8'h7F);
    check({tag, " dp"},  {7'b0, dp_o}, 8'h01);
  endtask

  // Each slot must hold its value for exactly 4 sampled cycles.
  task automatic check_slots(input string fr, input int lo, input int hi,
                             input logic [63:0] an_v, input logic [55:0] seg_v,
                             input logic [7:0] dp_v);
    for (int k = lo; k <= hi; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_i);
        check($sformatf("%s s%0d c%0d an", fr, k, c), an_o, an_v[8*k +: 8]);
        check($sformatf("%s s%0d c%0d seg", fr, k, c), {1'b0, seg_o}, {1'b0, seg_v[7*k +: 7]});
        check($sformatf("%s s%0d c%0d dp", fr, k, c), {7'b0, dp_o}, {7'b0, dp_v[k]});
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    time_i  = 36'h0;
    view_i  = 1'b0;
    hold_i  = 1'b0;
    blank_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_idle("reset");
    reset = 1'b0;

    // Asynchronous reset mid-scan, observed between clock edges
    repeat (10) @(negedge clk_i);
    #2 reset = 1'b1;
    #1 check_idle("async reset");
    @(negedge clk_i);
    check_idle("held reset");
    reset = 1'b0;
    @(negedge clk_i);
    check("first an", an_o, 8'hFE);
    check("first seg", {1'b0, seg_o}, 8'h40);
    check("first dp", {7'b0, dp_o}, 8'h01);

    time_i = 36'h0_1234_5678;
    repeat (31) @(negedge clk_i);

    // view_i changes mid-frame must not affect the frame in progress
    view_i = 1'b1;
    check_slots("view0", 0, 7, AN_V0, SEG_F1, 8'hD7);

    view_i = 1'b0;
    time_i = 36'h0_0000_0001;
    check_slots("view1", 0, 7, AN_V1, SEG_F2, 8'hAB);

    check_slots("capture", 0, 2, AN_V0, SEG_F3, 8'hD7);
    time_i = 36'h0_0000_0009;
    check_slots("capture", 3, 7, AN_V0, SEG_F3, 8'hD7);

    time_i = 36'h0_0059_9999;
    hold_i = 1'b1;
    check_slots("new9", 0, 7, AN_V0, SEG_F4, 8'hD7);

    check_slots("held", 0, 3, AN_V0, SEG_F4, 8'hD7);
    hold_i = 1'b0;
    check_slots("held", 4, 7, AN_V0, SEG_F4, 8'hD7);

    // A hold pulse away from the boundary is ignored
    check_slots("released", 0, 2, AN_V0, SEG_F6, 8'hD7);
    hold_i = 1'b1;
    time_i = 36'h0;
    check_slots("released", 3, 3, AN_V0, SEG_F6, 8'hD7);
    hold_i = 1'b0;
    check_slots("released", 4, 7, AN_V0, SEG_F6, 8'hD7);

    blank_i = 1'b1;
    time_i  = 36'h0_0A00_0000;
    check_slots("blank0", 0, 7, AN_B4, SEG_F7, 8'hF7);

    view_i = 1'b1;
    time_i = 36'h0_0000_0100;
    check_slots("invalid", 0, 7, AN_V0, SEG_F8, 8'hD7);

    check_slots("blank1", 0, 4, AN_B3, SEG_F9, 8'hFB);

    // Reset mid-frame restarts at digit 0 with an empty snapshot
    #2 reset = 1'b1;
    #1 check_idle("midframe reset");
    @(negedge clk_i);
    reset = 1'b0;
    @(negedge clk_i);
    check("restart an", an_o, 8'hFE);
    check("restart seg", {1'b0, seg_o}, 8'h40);
    check("restart dp", {7'b0, dp_o}, 8'h01);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
